execute_stage: RTL and testbench
================================

# execute_stage

Execute (E) stage of the five-stage MIPS pipeline. Computes the ALU result for the instruction in E. Runs a multi-cycle multiply/divide unit (MDU) that owns the HI/LO registers. Registers everything into the E/M pipeline register consumed by the Memory stage. Asserts a busy flag that the hazard unit uses to stall Decode while the MDU is occupied.

## Interface
- MULT_LAT, 5: cycles the MDU stays busy for mult/multu.
- DIV_LAT, 10: cycles the MDU stays busy for div/divu.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- E_PC  in  32  PC of instruction in E.
- E_Ins  in  32  instruction word in E; [10:6] is shamt.
- E_A  in  32  forwarded rs value.
- E_B  in  32  forwarded rt value.
- E_imm32  in  32  extended immediate.
- E_bsel  in  1  ALU operand B select: 0 = E_B, 1 = E_imm32.
- E_alu_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 LUI, 5 SLT, 6 SLTU, 7 SLL.
- E_md_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 are treated as none.
- E_branchTrue  in  1  branch outcome, passed through.
- E_busy  out  1  MDU occupied or being started this cycle.
- M_PC, M_Ins  out  32 each  registered E_PC / E_Ins.
- M_ALU_Y  out  32  registered result.
- M_rt_data  out  32  registered E_B (store data).
- M_branchTrue  out  1  registered E_branchTrue.

## Operation
- ALU operand B = E_bsel ? E_imm32 : E_B. All arithmetic is 32-bit, wrap-around, with no overflow trap.
- ALU ops:
  - LUI = B<<16.
  - SLT is a signed compare; SLTU is unsigned. Both return 32'd1 or 32'd0.
  - SLL = B << E_Ins[10:6].
- E result mux: md_op 5 gives HI, md_op 6 gives LO, otherwise the ALU result.
- MDU states: IDLE and BUSY, with a down-counter cnt.
- Start (md_op 1–4) in IDLE:
  - Compute the full result from E_A/E_B that cycle.
  - mult/multu: 64-bit product, {HI,LO}.
  - div/divu: LO = quotient, HI = remainder. Signed div truncates toward zero; the remainder takes the sign of the dividend.
  - Latch the result into pending registers, load cnt with LAT, go to BUSY.
- Divisor 0: the MDU still goes BUSY for DIV_LAT cycles, but HI/LO stay unchanged at commit.
- BUSY: cnt decrements each cycle. On the edge where cnt goes 1→0, pending HI/LO are written and the state returns to IDLE.
- mthi/mtlo in IDLE: HI or LO takes E_A at the clock edge.
- Start, mthi or mtlo arriving while in BUSY is ignored. The hazard unit guarantees this never happens, but the block stays defensive.
- mfhi/mflo while BUSY returns the old HI/LO. The hazard unit is responsible for stalling these.
- E_busy = (state == BUSY) | (state == IDLE & md_op in 1–4). This is combinational, so the hazard unit sees it in the start cycle.
- The E/M register updates every cycle and has no stall input. A bubble in E arrives upstream as E_Ins = 0 with md_op = 0.

## Timing
- While reset = 0 at a rising edge, the following are cleared:
  - M_PC, M_Ins, M_ALU_Y, M_rt_data, M_branchTrue all go to 0.
  - HI, LO and the pending registers go to 0.
  - State goes to IDLE and cnt to 0.
  - E_busy then reads 0 unless a start is present on the inputs.
- Reset mid-operation aborts the MDU; the pending result is discarded.
- ALU/E/M latency is 1 cycle: inputs at edge n appear on M_* after edge n.
- MDU latency, with the start instruction in E during cycle t:
  - E_busy is high for cycles t through t+LAT.
  - HI/LO hold the new value from edge t+LAT onward.
  - E_busy is low in cycle t+LAT+1.
  - An mfhi in E during cycle t+LAT+1 reads the new value.
- Back-to-back: a start presented in the cycle E_busy first falls is accepted.

## Test plan
- Reset: hold reset = 0 for 2 cycles with nonzero inputs. All M_* read 0, HI = LO = 0, and E_busy = 0 when md_op = 0.
- ALU sweep:
  - A = 0xFFFFFFFF, B = 1, ADD → M_ALU_Y = 0.
  - SLT → 1; SLTU → 0.
  - LUI with imm 0x1234 (bsel = 1) → 0x12340000.
  - SLL with B = 1, shamt = 31 → 0x80000000.
  - Each result appears one cycle later alongside the matching M_PC/M_Ins.
- mult: A = 0xFFFFFFFE (−2), B = 3.
  - E_busy is high for 6 cycles (t..t+5).
  - Then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - multu with the same operands gives HI = 2, LO = 0xFFFFFFFA.
- div: A = −7, B = 2 gives LO = 0xFFFFFFFD (−3) and HI = 0xFFFFFFFF (−1), with busy for 11 cycles.
- div by 0: with HI = LO = 5 set via mthi/mtlo, a div 9/0 shows busy for 11 cycles, and HI = LO = 5 afterwards.
- Reset mid-operation and an ignored start:
  - Drive a second mult while BUSY → the result is that of the first operation only.
  - Pull reset = 0 on cycle t+2 of a div → E_busy is 0 and HI = LO = 0 after the edge, with no late commit.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage of the five-stage MIPS pipeline: ALU, multi-cycle mult/div unit
// owning HI/LO, and the E/M pipeline register feeding the Memory stage.
module execute_stage #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_Ins,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic [31:0] E_imm32,
  input  logic        E_bsel,
  input  logic [2:0]  E_alu_op,
  input  logic [3:0]  E_md_op,
  input  logic        E_branchTrue,
  output logic        E_busy,
  output logic [31:0] M_PC,
  output logic [31:0] M_Ins,
  output logic [31:0] M_ALU_Y,
  output logic [31:0] M_rt_data,
  output logic        M_branchTrue
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_LUI  = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_SLTU = 3'd6;
  localparam logic [2:0] ALU_SLL  = 3'd7;

  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  logic [0:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      hi_r, lo_r;
  logic [31:0]      pend_hi_r, pend_lo_r;
  logic             pend_wr_r;

  logic [31:0]      op_b_s;
  logic [31:0]      alu_y_s;
  logic [31:0]      e_result_s;
  logic             start_s;
  logic [31:0]      md_hi_s, md_lo_s;
  logic             md_wr_s;
  logic [CNT_W-1:0] md_lat_s;

  logic [63:0]      prod_signed_s, prod_unsigned_s;
  logic             div_zero_s;
  logic             div_signed_s;
  logic [31:0]      divisor_s;
  logic [31:0]      div_n_s, div_d_s;
  logic [31:0]      div_q_mag_s, div_r_mag_s;
  logic [31:0]      div_q_s, div_r_s;

  assign op_b_s = E_bsel ? E_imm32 : E_B;

  // ALU result for the instruction in E
  always_comb begin
    alu_y_s = 32'd0;
    case (E_alu_op)
      ALU_ADD:  alu_y_s = E_A + op_b_s;
      ALU_SUB:  alu_y_s = E_A - op_b_s;
      ALU_AND:  alu_y_s = E_A & op_b_s;
      ALU_OR:   alu_y_s = E_A | op_b_s;
      ALU_LUI:  alu_y_s = {op_b_s[15:0], 16'h0000};
      ALU_SLT:  alu_y_s = ($signed(E_A) < $signed(op_b_s)) ? 32'd1 : 32'd0;
      ALU_SLTU: alu_y_s = (E_A < op_b_s) ? 32'd1 : 32'd0;
      ALU_SLL:  alu_y_s = op_b_s << E_Ins[10:6];
      default:  alu_y_s = 32'd0;
    endcase
  end

  // mfhi/mflo read the architectural HI/LO, so a read during BUSY sees the old value
  always_comb begin
    e_result_s = alu_y_s;
    case (E_md_op)
      MD_MFHI: e_result_s = hi_r;
      MD_MFLO: e_result_s = lo_r;
      default: e_result_s = alu_y_s;
    endcase
  end

  assign prod_signed_s   = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
  assign prod_unsigned_s = {32'd0, E_A} * {32'd0, E_B};

  // One shared unsigned divider; signed division runs on magnitudes and fixes signs after.
  // A zero divisor is replaced by 1 so the divider never sees 0; its result is never committed.
  assign div_zero_s   = (E_B == 32'd0);
  assign div_signed_s = (E_md_op == MD_DIV);
  assign divisor_s    = div_zero_s ? 32'd1 : E_B;
  assign div_n_s      = (div_signed_s && E_A[31]) ? (32'd0 - E_A) : E_A;
  assign div_d_s      = (div_signed_s && divisor_s[31]) ? (32'd0 - divisor_s) : divisor_s;
  assign div_q_mag_s  = div_n_s / div_d_s;
  assign div_r_mag_s  = div_n_s % div_d_s;
  assign div_q_s      = (div_signed_s && (E_A[31] ^ E_B[31])) ? (32'd0 - div_q_mag_s) : div_q_mag_s;
  assign div_r_s      = (div_signed_s && E_A[31]) ? (32'd0 - div_r_mag_s) : div_r_mag_s;

  // MDU start decode: result, write-enable and latency captured when a start is accepted
  always_comb begin
    start_s  = 1'b0;
    md_hi_s  = 32'd0;
    md_lo_s  = 32'd0;
    md_wr_s  = 1'b0;
    md_lat_s = {CNT_W{1'b0}};
    if (state_r == ST_IDLE) begin
      case (E_md_op)
        MD_MULT: begin
          start_s            = 1'b1;
          {md_hi_s, md_lo_s} = prod_signed_s;
          md_wr_s            = 1'b1;
          md_lat_s           = CNT_W'(MULT_LAT);
        end
        MD_MULTU: begin
          start_s            = 1'b1;
          {md_hi_s, md_lo_s} = prod_unsigned_s;
          md_wr_s            = 1'b1;
          md_lat_s           = CNT_W'(MULT_LAT);
        end
        MD_DIV, MD_DIVU: begin
          start_s  = 1'b1;
          md_hi_s  = div_r_s;
          md_lo_s  = div_q_s;
          md_wr_s  = ~div_zero_s;
          md_lat_s = CNT_W'(DIV_LAT);
        end
        default: begin
          start_s = 1'b0;
        end
      endcase
    end else begin
      start_s = 1'b0;
    end
  end

  assign E_busy = (state_r == ST_BUSY) | start_s;

  // E/M pipeline register, updated every cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      M_PC         <= 32'd0;
      M_Ins        <= 32'd0;
      M_ALU_Y      <= 32'd0;
      M_rt_data    <= 32'd0;
      M_branchTrue <= 1'b0;
    end else begin
      M_PC         <= E_PC;
      M_Ins        <= E_Ins;
      M_ALU_Y      <= e_result_s;
      M_rt_data    <= E_B;
      M_branchTrue <= E_branchTrue;
    end
  end

  // MDU sequencing and HI/LO ownership; anything but the countdown is ignored while BUSY
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            pend_hi_r <= md_hi_s;
            pend_lo_r <= md_lo_s;
            pend_wr_r <= md_wr_s;
            cnt_r     <= md_lat_s;
            state_r   <= ST_BUSY;
          end else if (E_md_op == MD_MTHI) begin
            hi_r <= E_A;
          end else if (E_md_op == MD_MTLO) begin
            lo_r <= E_A;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_r <= CNT_W'(1)) begin
            if (pend_wr_r) begin
              hi_r <= pend_hi_r;
              lo_r <= pend_lo_r;
            end else begin
              hi_r <= hi_r;
            end
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: ALU sweep, MDU latencies,
// HI/LO results, divide-by-zero, ignored starts and reset abort.
module tb_execute_stage;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] E_PC, E_Ins, E_A, E_B, E_imm32;
  logic        E_bsel;
  logic [2:0]  E_alu_op;
  logic [3:0]  E_md_op;
  logic        E_branchTrue;
  logic        E_busy;
  logic [31:0] M_PC, M_Ins, M_ALU_Y, M_rt_data;
  logic        M_branchTrue;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  execute_stage #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset),
    .E_PC(E_PC), .E_Ins(E_Ins), .E_A(E_A), .E_B(E_B), .E_imm32(E_imm32),
    .E_bsel(E_bsel), .E_alu_op(E_alu_op), .E_md_op(E_md_op),
    .E_branchTrue(E_branchTrue), .E_busy(E_busy),
    .M_PC(M_PC), .M_Ins(M_Ins), .M_ALU_Y(M_ALU_Y), .M_rt_data(M_rt_data),
    .M_branchTrue(M_branchTrue)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic bsel,
                        input logic [2:0] aop, input logic [3:0] mop, input logic br);
    E_PC = pc; E_Ins = ins; E_A = a; E_B = b; E_imm32 = imm;
    E_bsel = bsel; E_alu_op = aop; E_md_op = mop; E_branchTrue = br;
  endtask

  task automatic bubble;
    set_in(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, MD_NONE, 1'b0);
  endtask

  task automatic md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    set_in(32'h0000_0200, 32'd0, a, b, 32'd0, 1'b0, 3'd0, op, 1'b0);
  endtask

  // Start in the current cycle t, expect busy for t..t+lat and low at t+lat+1
  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat);
    int high_cycles;
    md(op, a, b);
    #1;
    high_cycles = E_busy ? 1 : 0;
    tick;
    bubble;
    for (int i = 1; i <= lat; i++) begin
      #1;
      if (E_busy) high_cycles++;
      tick;
    end
    #1;
    chk({tag, "_busy_cycles"}, 32'(high_cycles), 32'(lat + 1));
    chk({tag, "_busy_low_after"}, {31'd0, E_busy}, 32'd0);
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    md(MD_MFHI, 32'd0, 32'd0);
    tick;
    chk({tag, "_hi"}, M_ALU_Y, exp_hi);
    md(MD_MFLO, 32'd0, 32'd0);
    tick;
    chk({tag, "_lo"}, M_ALU_Y, exp_lo);
    bubble;
  endtask

  initial begin
    // Reset with nonzero inputs and no MDU op
    reset = 1'b0;
    set_in(32'hDEAD_BEEF, 32'h1234_5678, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
           1'b1, 3'd0, MD_NONE, 1'b1);
    tick;
    tick;
    chk("rst_M_PC", M_PC, 32'd0);
    chk("rst_M_Ins", M_Ins, 32'd0);
    chk("rst_M_ALU_Y", M_ALU_Y, 32'd0);
    chk("rst_M_rt_data", M_rt_data, 32'd0);
    chk("rst_M_branchTrue", {31'd0, M_branchTrue}, 32'd0);
    chk("rst_busy", {31'd0, E_busy}, 32'd0);
    reset = 1'b1;
    read_hilo("rst", 32'd0, 32'd0);

    // ALU sweep, each result one cycle later with its PC/Ins
    set_in(32'h0000_0100, 32'h1111_1111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'd0, MD_NONE, 1'b1);
    tick;
    chk("add_y", M_ALU_Y, 32'd0);
    chk("add_pc", M_PC, 32'h0000_0100);
    chk("add_ins", M_Ins, 32'h1111_1111);
    chk("add_rt", M_rt_data, 32'd1);
    chk("add_br", {31'd0, M_branchTrue}, 32'd1);
    set_in(32'h0000_0104, 32'h2222_2222, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'd1, MD_NONE, 1'b0);
    tick;
    chk("sub_y", M_ALU_Y, 32'hFFFF_FFFE);
    chk("sub_pc", M_PC, 32'h0000_0104);
    chk("sub_br", {31'd0, M_branchTrue}, 32'd0);
    set_in(32'h0000_0108, 32'h3333_3333, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'd5, MD_NONE, 1'b0);
    tick;
    chk("slt_y", M_ALU_Y, 32'd1);
    chk("slt_ins", M_Ins, 32'h3333_3333);
    set_in(32'h0000_010C, 32'h4444_4444, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'd6, MD_NONE, 1'b0);
    tick;
    chk("sltu_y", M_ALU_Y, 32'd0);
    set_in(32'h0000_0110, 32'h5555_5555, 32'hFFFF_FFFF, 32'h0000_0F0F, 32'd0, 1'b0, 3'd2, MD_NONE, 1'b0);
    tick;
    chk("and_y", M_ALU_Y, 32'h0000_0F0F);
    set_in(32'h0000_0114, 32'h6666_6666, 32'hF000_0000, 32'h0000_000F, 32'd0, 1'b0, 3'd3, MD_NONE, 1'b0);
    tick;
    chk("or_y", M_ALU_Y, 32'hF000_000F);
    set_in(32'h0000_0118, 32'h7777_7777, 32'd0, 32'h9999_9999, 32'h0000_1234, 1'b1, 3'd4, MD_NONE, 1'b0);
    tick;
    chk("lui_y", M_ALU_Y, 32'h1234_0000);
    chk("lui_rt", M_rt_data, 32'h9999_9999);
    chk("lui_pc", M_PC, 32'h0000_0118);
    set_in(32'h0000_011C, 32'h0000_07C0, 32'd0, 32'd1, 32'd0, 1'b0, 3'd7, MD_NONE, 1'b0);
    tick;
    chk("sll_y", M_ALU_Y, 32'h8000_0000);
    chk("sll_ins", M_Ins, 32'h0000_07C0);
    bubble;

    // Multiply, signed and unsigned
    run_md("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5);
    read_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

    // Divide, signed and unsigned
    run_md("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu", MD_DIVU, 32'd100, 32'd7, 10);
    read_hilo("divu", 32'd2, 32'd14);

    // Back-to-back: second start lands in the cycle busy first falls
    run_md("b2b_mult", MD_MULT, 32'd2, 32'd3, 5);
    run_md("b2b_multu", MD_MULTU, 32'h0001_0000, 32'h0001_0000, 5);
    read_hilo("b2b", 32'd1, 32'd0);

    // Divide by zero leaves HI/LO untouched
    md(MD_MTHI, 32'd5, 32'd0);
    tick;
    md(MD_MTLO, 32'd5, 32'd0);
    tick;
    bubble;
    read_hilo("mtx", 32'd5, 32'd5);
    run_md("div0", MD_DIV, 32'd9, 32'd0, 10);
    read_hilo("div0", 32'd5, 32'd5);

    // Start/mthi/mtlo during BUSY are ignored
    begin
      int high_cycles;
      md(MD_MULT, 32'd2, 32'd3);
      #1;
      high_cycles = E_busy ? 1 : 0;
      tick;
      for (int i = 1; i <= 5; i++) begin
        if (i == 1) md(MD_MULT, 32'd7, 32'd7);
        else if (i == 2) md(MD_MTHI, 32'h0000_DEAD, 32'd0);
        else if (i == 3) md(MD_MTLO, 32'h0000_BEEF, 32'd0);
        else bubble;
        #1;
        if (E_busy) high_cycles++;
        tick;
      end
      bubble;
      #1;
      chk("ign_busy_cycles", 32'(high_cycles), 32'd6);
      chk("ign_busy_low_after", {31'd0, E_busy}, 32'd0);
      read_hilo("ign", 32'd0, 32'd6);
    end

    // Reset during a divide aborts it with no late commit
    md(MD_MTHI, 32'h0000_0077, 32'd0);
    tick;
    md(MD_DIV, 32'd100, 32'd7);
    #1;
    chk("abort_busy_start", {31'd0, E_busy}, 32'd1);
    tick;
    bubble;
    tick;
    reset = 1'b0;
    tick;
    chk("abort_busy_after_rst", {31'd0, E_busy}, 32'd0);
    reset = 1'b1;
    repeat (12) tick;
    chk("abort_busy_late", {31'd0, E_busy}, 32'd0);
    read_hilo("abort", 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
